// File: rtl/guitar_led_pkg.sv
`default_nettype none
// ============================================================================
// Package : guitar_led_pkg
// Brief   : Shared LED-stretcher state encodings and default timing constants.
// Rev     : 1.0 - initial release
// ============================================================================
package guitar_led_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_HOLD = 2'd1;
    localparam state_t ST_GAP  = 2'd2;

    // Defaults match a 50 MHz board clock with a 1 ms tick.
    localparam int DEF_N_CH       = 18;
    localparam int DEF_PRESCALE   = 50000;
    localparam int DEF_HOLD_TICKS = 100;
    localparam int DEF_GAP_TICKS  = 20;
    localparam int DEF_CNT_W      = 8;

endpackage : guitar_led_pkg
`default_nettype wire

// File: rtl/led_stretch_ch.sv
`default_nettype none
// ============================================================================
// Module  : led_stretch_ch
// Brief   : One LED channel: minimum on-time, then a forced off-gap with a
//           one-deep pending trigger.
// Rev     : 1.0 - initial release
// ============================================================================
module led_stretch_ch
    import guitar_led_pkg::*;
#(
    parameter int HOLD_TICKS = DEF_HOLD_TICKS,
    parameter int GAP_TICKS  = DEF_GAP_TICKS,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic tick,
    input  logic trig,
    output logic led,
    output logic active
);

    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'(GAP_TICKS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_pend;
    logic             w_pend_nxt;
    logic             r_led;
    logic             r_active;
    logic             w_led_nxt;
    logic             w_active_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_pend   <= 1'b0;
            r_led    <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pend   <= w_pend_nxt;
            r_led    <= w_led_nxt;
            r_active <= w_active_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        if (!en) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_pend_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt  = '0;
                    w_pend_nxt = 1'b0;
                    if (trig) w_state_nxt = ST_HOLD;
                end
                ST_HOLD: begin
                    w_pend_nxt = 1'b0;
                    // A retrigger outranks expiry so the LED never drops for a cycle.
                    if (trig) begin
                        w_cnt_nxt = '0;
                    end else if (tick) begin
                        if (r_cnt == c_hold_last) begin
                            w_state_nxt = ST_GAP;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (tick && (r_cnt == c_gap_last)) begin
                        w_state_nxt = (r_pend || trig) ? ST_HOLD : ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_pend_nxt  = 1'b0;
                    end else begin
                        if (tick) w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (trig) w_pend_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_pend_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_led_nxt    = (w_state_nxt == ST_HOLD);
        w_active_nxt = (w_state_nxt == ST_HOLD) || (w_state_nxt == ST_GAP);
    end

    assign led    = r_led;
    assign active = r_active;

endmodule : led_stretch_ch
`default_nettype wire

// File: rtl/led_pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module  : led_pulse_stretch
// Brief   : Shared tick prescaler driving N_CH independent LED pulse stretchers.
// Rev     : 1.0 - initial release
// ============================================================================
module led_pulse_stretch
    import guitar_led_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int PRESCALE   = DEF_PRESCALE,
    parameter int HOLD_TICKS = DEF_HOLD_TICKS,
    parameter int GAP_TICKS  = DEF_GAP_TICKS,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N_CH-1:0] trig,
    output logic [N_CH-1:0] led,
    output logic [N_CH-1:0] active
);

    localparam int                 c_pre_w    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PRESCALE - 1);

    logic [c_pre_w-1:0] r_pre;
    logic               w_tick;

    // Free-running phase; only en=0 or reset re-aligns it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre <= '0;
        end else if (!en || (r_pre == c_pre_last)) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_pre_w'(1);
        end
    end

    assign w_tick = en && (r_pre == c_pre_last);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        led_stretch_ch #(
            .HOLD_TICKS (HOLD_TICKS),
            .GAP_TICKS  (GAP_TICKS),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .tick   (w_tick),
            .trig   (trig[i]),
            .led    (led[i]),
            .active (active[i])
        );
    end

endmodule : led_pulse_stretch
`default_nettype wire

// File: tb/tb_led_pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_pulse_stretch
// Brief   : Directed, table-driven bench for led_pulse_stretch.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_led_pulse_stretch;

    localparam int N_CH = 18;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [N_CH-1:0] trig;
    logic [N_CH-1:0] led;
    logic [N_CH-1:0] active;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    led_pulse_stretch #(
        .N_CH       (N_CH),
        .PRESCALE   (4),
        .HOLD_TICKS (3),
        .GAP_TICKS  (2),
        .CNT_W      (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .trig   (trig),
        .led    (led),
        .active (active)
    );

    typedef struct {
        logic [N_CH-1:0] trig;
        logic            en;
        int              reps;
        logic [N_CH-1:0] led;
        logic [N_CH-1:0] act;
    } vec_t;

    vec_t tbl[$];

    localparam logic [N_CH-1:0] ALL = 18'h3FFFF;
    localparam logic [N_CH-1:0] B0  = 18'h00001;
    localparam logic [N_CH-1:0] B3  = 18'h00008;
    localparam logic [N_CH-1:0] B5  = 18'h00020;
    localparam logic [N_CH-1:0] Z   = 18'h00000;

    task automatic add(input logic [N_CH-1:0] t, input logic e, input int n,
                       input logic [N_CH-1:0] l, input logic [N_CH-1:0] a);
        vec_t v;
        v.trig = t; v.en = e; v.reps = n; v.led = l; v.act = a;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx,
                         input logic [N_CH-1:0] le, input logic [N_CH-1:0] ae);
        vectors++;
        if (led !== le || active !== ae) begin
            miscompares++;
            $display("FAIL %s[%0d]: led=%h active=%h, expected led=%h active=%h",
                     name, idx, led, active, le, ae);
        end
    endtask

    // en low for one edge: all channels IDLE, prescaler phase back to 0.
    task automatic realign();
        trig = Z;
        en   = 1'b0;
        step();
        check("realign", 0, Z, Z);
        en = 1'b1;
    endtask

    // Edge e=1 is the first after realign; ticks land on e=4,8,12,...
    task automatic run_pend(input int variant);
        logic            t;
        logic [N_CH-1:0] le, ae;
        realign();
        for (int e = 1; e <= 45; e++) begin
            case (variant)
                0:       t = (e == 1) || (e == 14);
                1:       t = (e == 1) || (e == 13) || (e == 15) || (e == 17);
                default: t = (e == 1) || (e == 20);
            endcase
            trig = t ? B3 : Z;
            step();
            le = (((e >= 1) && (e <= 11)) || ((e >= 20) && (e <= 31))) ? B3 : Z;
            ae = ((e >= 1) && (e <= 39)) ? B3 : Z;
            check($sformatf("gap_pend_v%0d", variant), e, le, ae);
        end
        trig = Z;
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        trig = ALL;
        #2 rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold", i, Z, Z);
        end
        rst  = 1'b1;
        trig = Z;
        for (int i = 0; i < 50; i++) begin
            step();
            check("post_reset_idle", i, Z, Z);
        end

        // Single hit on ch0 just before a tick: shortest on-time (9 cycles).
        add(Z,   1'b0, 1,  Z,   Z);
        add(Z,   1'b1, 2,  Z,   Z);
        add(B0,  1'b1, 1,  B0,  B0);
        add(Z,   1'b1, 8,  B0,  B0);
        add(Z,   1'b1, 8,  Z,   B0);
        add(Z,   1'b1, 2,  Z,   Z);
        // All channels on a tick edge: longest on-time (12 cycles), all in lockstep.
        add(Z,   1'b0, 1,  Z,   Z);
        add(Z,   1'b1, 3,  Z,   Z);
        add(ALL, 1'b1, 1,  ALL, ALL);
        add(Z,   1'b1, 11, ALL, ALL);
        add(Z,   1'b1, 8,  Z,   ALL);
        add(Z,   1'b1, 2,  Z,   Z);
        // Retrigger ch5 six cycles into HOLD: 11 cycles from the second trig.
        add(Z,   1'b0, 1,  Z,   Z);
        add(Z,   1'b1, 2,  Z,   Z);
        add(B5,  1'b1, 1,  B5,  B5);
        add(Z,   1'b1, 5,  B5,  B5);
        add(B5,  1'b1, 1,  B5,  B5);
        add(Z,   1'b1, 10, B5,  B5);
        add(Z,   1'b1, 8,  Z,   B5);
        add(Z,   1'b1, 1,  Z,   Z);
        // Retrigger ch5 on the exact expiry edge.
        add(Z,   1'b0, 1,  Z,   Z);
        add(Z,   1'b1, 2,  Z,   Z);
        add(B5,  1'b1, 1,  B5,  B5);
        add(Z,   1'b1, 8,  B5,  B5);
        add(B5,  1'b1, 1,  B5,  B5);
        add(Z,   1'b1, 11, B5,  B5);
        add(Z,   1'b1, 8,  Z,   B5);
        add(Z,   1'b1, 1,  Z,   Z);

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                trig = tbl[i].trig;
                en   = tbl[i].en;
                step();
                check("table", i, tbl[i].led, tbl[i].act);
            end
        end
        trig = Z;
        en   = 1'b1;

        run_pend(0);
        run_pend(1);
        run_pend(2);

        // en dropped mid-hold.
        realign();
        trig = B0;
        step();
        check("dis_hold", 0, B0, B0);
        trig = Z;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("dis_hold", i, B0, B0);
        end
        en = 1'b0;
        step();
        check("dis_clear", 0, Z, Z);
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("dis_stay_off", i, Z, Z);
        end

        // Asynchronous reset mid-hold, checked before any further clock edge.
        realign();
        trig = B0;
        step();
        trig = Z;
        step();
        check("arst_pre", 0, B0, B0);
        rst = 1'b0;
        #2;
        check("arst_immediate", 0, Z, Z);
        step();
        check("arst_held", 0, Z, Z);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("arst_stay_off", i, Z, Z);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_led_pulse_stretch
`default_nettype wire
